// File: rtl/spot_manager_if.sv
// spot_manager_if: request/response bundle between the lot controller and its client; cancel exists only with SPOT_CANCEL_EN
interface spot_manager_if;
  logic       hour_tick;
  logic       park;
  logic       checkout;
  logic [1:0] spot_sel;
  logic [1:0] park_size;
  logic       leave;
`ifdef SPOT_CANCEL_EN
  logic       cancel;
`endif
  logic [8:0] start;
  logic [8:0] final1;
  logic [1:0] size;
  logic       calculate_fare;
  logic       park_ack;
  logic       req_nack;
  logic       busy;
  logic [3:0] occupied;
  logic       lot_full;
  logic [8:0] now;
  modport master (
    output hour_tick, park, checkout, spot_sel, park_size, leave,
`ifdef SPOT_CANCEL_EN
    output cancel,
`endif
    input start, final1, size, calculate_fare, park_ack, req_nack, busy, occupied, lot_full, now
  );
  modport slave (
    input hour_tick, park, checkout, spot_sel, park_size, leave,
`ifdef SPOT_CANCEL_EN
    input cancel,
`endif
    output start, final1, size, calculate_fare, park_ack, req_nack, busy, occupied, lot_full, now
  );
endinterface

// File: rtl/spot_manager.sv
// spot_manager: four-spot parking lot controller with lot clock and billing handoff; SPOT_CANCEL_EN adds billing cancel
module spot_manager #(
  parameter logic [8:0] TIME_LIMIT = 9'd511
) (
  input logic           clock,
  input logic           gl_reset,
  spot_manager_if.slave b
);
  typedef enum logic [1:0] {S_IDLE, S_BILLING, S_RELEASE} state_e;
  state_e     state_q, state_d;
  logic [8:0] now_q, now_d;
  logic [3:0] occ_q, occ_d;
  logic [8:0] entry_q [4];
  logic [8:0] entry_d [4];
  logic [1:0] size_q [4];
  logic [1:0] size_d [4];
  logic [1:0] sel_q, sel_d;
  logic [8:0] fin_q, fin_d;
  logic       ack_q, ack_d, nack_q, nack_d;
  logic       cancel_in;
`ifdef SPOT_CANCEL_EN
  assign cancel_in = b.cancel;
`else
  assign cancel_in = 1'b0;
`endif
  wire billing = state_q == S_BILLING;
  assign b.start          = billing ? entry_q[sel_q] : 9'd0;
  assign b.final1         = billing ? fin_q : 9'd0;
  assign b.size           = billing ? size_q[sel_q] : 2'd0;
  assign b.calculate_fare = billing;
  assign b.busy           = state_q != S_IDLE;
  assign b.occupied       = occ_q;
  assign b.lot_full       = &occ_q;
  assign b.now            = now_q;
  assign b.park_ack       = ack_q;
  assign b.req_nack       = nack_q;
  // next state: saturating lot clock, request handling in idle, billing exit
  always_comb begin
    state_d = state_q;
    now_d   = (b.hour_tick && now_q < TIME_LIMIT) ? now_q + 9'd1 : now_q;
    occ_d   = occ_q;
    entry_d = entry_q;
    size_d  = size_q;
    sel_d   = sel_q;
    fin_d   = fin_q;
    ack_d   = 1'b0;
    nack_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (b.park) begin
          if (!occ_q[b.spot_sel] && b.park_size != 2'b00) begin
            occ_d[b.spot_sel]   = 1'b1;
            entry_d[b.spot_sel] = now_q;
            size_d[b.spot_sel]  = b.park_size;
            ack_d               = 1'b1;
          end else nack_d = 1'b1;
        end else if (b.checkout) begin
          if (occ_q[b.spot_sel]) begin
            sel_d   = b.spot_sel;
            fin_d   = now_q;
            state_d = S_BILLING;
          end else nack_d = 1'b1;
        end
      end
      S_BILLING: state_d = cancel_in ? S_IDLE : b.leave ? S_RELEASE : S_BILLING;
      S_RELEASE: begin
        occ_d[sel_q] = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (gl_reset) begin
      state_q <= S_IDLE;
      now_q   <= '0;
      occ_q   <= '0;
      entry_q <= '{default: '0};
      size_q  <= '{default: '0};
      sel_q   <= '0;
      fin_q   <= '0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      now_q   <= now_d;
      occ_q   <= occ_d;
      entry_q <= entry_d;
      size_q  <= size_d;
      sel_q   <= sel_d;
      fin_q   <= fin_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
    end
  end
endmodule

// File: tb/tb_spot_manager.sv
// tb_spot_manager: directed vector table plus hand sequences for saturation, reset and cancel
module tb_spot_manager;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  spot_manager_if b ();
  spot_manager dut (.clock(clk), .gl_reset(rst), .b(b));
  typedef struct {
    logic       tk, pk, co;
    logic [1:0] sel, psz;
    logic       lv;
    logic       ack, nack;
    logic [3:0] occ;
    logic       busy, cf;
    logic [8:0] st, fin;
    logic [1:0] sz;
    logic [8:0] now;
    logic       full;
  } vec_t;
  vec_t v [16];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input logic tk, pk, co, input logic [1:0] sel, psz, input logic lv);
    @(negedge clk);
    b.hour_tick = tk;
    b.park      = pk;
    b.checkout  = co;
    b.spot_sel  = sel;
    b.park_size = psz;
    b.leave     = lv;
    @(posedge clk);
    #1;
  endtask
  initial begin
    b.hour_tick = 0; b.park = 0; b.checkout = 0; b.spot_sel = 0; b.park_size = 0; b.leave = 0;
`ifdef SPOT_CANCEL_EN
    b.cancel = 0;
`endif
    //          tk pk co sel psz lv  ack nack occ      busy cf st fin  sz now full
    v[0]  = '{0, 1, 0, 2, 1, 0,  1, 0, 4'b0100, 0, 0, 0,  0,  0, 71, 0};
    v[1]  = '{1, 0, 0, 0, 0, 0,  0, 0, 4'b0100, 0, 0, 0,  0,  0, 72, 0};
    v[2]  = '{1, 0, 0, 0, 0, 0,  0, 0, 4'b0100, 0, 0, 0,  0,  0, 73, 0};
    v[3]  = '{0, 0, 1, 2, 0, 0,  0, 0, 4'b0100, 1, 1, 71, 73, 1, 73, 0};
    v[4]  = '{1, 0, 0, 0, 0, 0,  0, 0, 4'b0100, 1, 1, 71, 73, 1, 74, 0};
    v[5]  = '{0, 1, 1, 0, 2, 0,  0, 0, 4'b0100, 1, 1, 71, 73, 1, 74, 0};
    v[6]  = '{0, 0, 0, 0, 0, 1,  0, 0, 4'b0100, 1, 0, 0,  0,  0, 74, 0};
    v[7]  = '{0, 0, 0, 0, 0, 0,  0, 0, 4'b0000, 0, 0, 0,  0,  0, 74, 0};
    v[8]  = '{0, 1, 0, 1, 0, 0,  0, 1, 4'b0000, 0, 0, 0,  0,  0, 74, 0};
    v[9]  = '{0, 0, 1, 3, 0, 0,  0, 1, 4'b0000, 0, 0, 0,  0,  0, 74, 0};
    v[10] = '{0, 1, 1, 0, 2, 0,  1, 0, 4'b0001, 0, 0, 0,  0,  0, 74, 0};
    v[11] = '{0, 1, 0, 1, 3, 0,  1, 0, 4'b0011, 0, 0, 0,  0,  0, 74, 0};
    v[12] = '{0, 1, 0, 2, 2, 0,  1, 0, 4'b0111, 0, 0, 0,  0,  0, 74, 0};
    v[13] = '{0, 1, 0, 3, 1, 0,  1, 0, 4'b1111, 0, 0, 0,  0,  0, 74, 1};
    v[14] = '{0, 1, 0, 1, 2, 0,  0, 1, 4'b1111, 0, 0, 0,  0,  0, 74, 1};
    v[15] = '{0, 0, 0, 0, 0, 1,  0, 0, 4'b1111, 0, 0, 0,  0,  0, 74, 1};
    cyc(0, 0, 0, 0, 0, 0);
    rst = 0;
    chk("reset_now", b.now, 0);
    chk("reset_occ", b.occupied, 0);
    chk("reset_busy", b.busy, 0);
    chk("reset_cf", b.calculate_fare, 0);
    chk("reset_ack", b.park_ack, 0);
    chk("reset_nack", b.req_nack, 0);
    for (int i = 0; i < 71; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("ticks71_now", b.now, 71);
    for (int i = 0; i < 16; i++) begin
      cyc(v[i].tk, v[i].pk, v[i].co, v[i].sel, v[i].psz, v[i].lv);
      chk($sformatf("v%0d_ack", i), b.park_ack, v[i].ack);
      chk($sformatf("v%0d_nack", i), b.req_nack, v[i].nack);
      chk($sformatf("v%0d_occ", i), b.occupied, v[i].occ);
      chk($sformatf("v%0d_busy", i), b.busy, v[i].busy);
      chk($sformatf("v%0d_cf", i), b.calculate_fare, v[i].cf);
      chk($sformatf("v%0d_start", i), b.start, v[i].st);
      chk($sformatf("v%0d_final1", i), b.final1, v[i].fin);
      chk($sformatf("v%0d_size", i), b.size, v[i].sz);
      chk($sformatf("v%0d_now", i), b.now, v[i].now);
      chk($sformatf("v%0d_full", i), b.lot_full, v[i].full);
    end
    for (int i = 0; i < 436; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("sat_510", b.now, 510);
    cyc(1, 0, 0, 0, 0, 0);
    chk("sat_511", b.now, 511);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("sat_hold", b.now, 511);
    cyc(0, 0, 1, 1, 0, 0);
    chk("bill2_start", b.start, 74);
    chk("bill2_final1", b.final1, 511);
    chk("bill2_size", b.size, 3);
    chk("bill2_cf", b.calculate_fare, 1);
    rst = 1;
    cyc(0, 0, 0, 0, 0, 1);
    rst = 0;
    chk("midbill_rst_busy", b.busy, 0);
    chk("midbill_rst_cf", b.calculate_fare, 0);
    chk("midbill_rst_occ", b.occupied, 0);
    chk("midbill_rst_now", b.now, 0);
    chk("midbill_rst_final1", b.final1, 0);
`ifdef SPOT_CANCEL_EN
    cyc(0, 1, 0, 0, 2, 0);
    chk("cx_park_ack", b.park_ack, 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("cx_bill_cf", b.calculate_fare, 1);
    chk("cx_bill_size", b.size, 2);
    b.cancel = 1;
    cyc(0, 0, 0, 0, 0, 1);
    b.cancel = 0;
    chk("cx_busy", b.busy, 0);
    chk("cx_cf", b.calculate_fare, 0);
    chk("cx_occ", b.occupied, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("cx_occ_hold", b.occupied, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
